// File: rtl/wbu_pkg.sv
// Shared types and constants for the write-back/commit stage.
package wbu_pkg;

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    COMMIT,
    NOTIFY,
    HALT
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Everything execute hands over for one retired instruction.
  typedef struct packed {
    logic [31:0] res;
    logic [31:0] pc_next;
    logic [4:0]  rd;
    logic        wen;
    logic        brch;
    logic        jump;
    logic        ebreak;
  } payload_t;

endpackage

// File: rtl/wbu_npc.sv
// Next-PC selection: jump or taken branch goes to target, otherwise fall through.
module wbu_npc
  import wbu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] target,
  input  logic        brch,
  input  logic        jump,
  input  logic        res0,
  output logic [31:0] npc,
  output logic        misalign
);

  logic taken;

  assign taken    = jump | (brch & res0);
  assign npc      = taken ? target : pc + PC_INC;
  assign misalign = |npc[1:0];

endmodule

// File: rtl/wbu_commit.sv
// Write-back/commit stage: register-file write, architectural PC, fetch
// notification, halt handling and retired-instruction counting.
module wbu_commit
  import wbu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 64
) (
  input  logic             clock,
  input  logic             i_rst,
  input  logic             i_pre_valid,
  output logic             o_pre_ready,
  input  logic [31:0]      i_res,
  input  logic [31:0]      i_pc_next,
  input  logic [4:0]       i_rd,
  input  logic             i_wen,
  input  logic             i_brch,
  input  logic             i_jump,
  input  logic             i_ebreak,
  output logic             o_rf_wen,
  output logic [4:0]       o_rf_waddr,
  output logic [31:0]      o_rf_wdata,
  output logic [31:0]      o_pc,
  output logic             o_post_valid,
  input  logic             i_post_ready,
  output logic             o_halt,
  output logic             o_misalign,
  output logic [CNT_W-1:0] o_commit_cnt
);

  state_t      state;
  payload_t    lat;
  logic [31:0] npc;
  logic        npc_misalign;

  wbu_npc u_npc (
    .pc       (o_pc),
    .target   (lat.pc_next),
    .brch     (lat.brch),
    .jump     (lat.jump),
    .res0     (lat.res[0]),
    .npc      (npc),
    .misalign (npc_misalign)
  );

  assign o_pre_ready = (state == IDLE);
  // Branches reuse res as the taken flag, so they never write rd; x0 is never written.
  assign o_rf_wen    = (state == COMMIT) && lat.wen && !lat.brch && (lat.rd != 5'd0);
  assign o_rf_waddr  = lat.rd;
  assign o_rf_wdata  = lat.res;

  always_ff @(posedge clock) begin
    if (i_rst) begin
      state        <= BOOT;
      lat          <= '0;
      o_pc         <= RESET_PC;
      o_post_valid <= 1'b0;
      o_halt       <= 1'b0;
      o_misalign   <= 1'b0;
      o_commit_cnt <= '0;
    end else begin
      case (state)
        // First fetch of RESET_PC; valid rises one cycle after reset releases.
        BOOT: begin
          if (o_post_valid && i_post_ready) begin
            o_post_valid <= 1'b0;
            state        <= IDLE;
          end else begin
            o_post_valid <= 1'b1;
          end
        end
        IDLE: begin
          if (i_pre_valid) begin
            lat.res     <= i_res;
            lat.pc_next <= i_pc_next;
            lat.rd      <= i_rd;
            lat.wen     <= i_wen;
            lat.brch    <= i_brch;
            lat.jump    <= i_jump;
            lat.ebreak  <= i_ebreak;
            state       <= COMMIT;
          end
        end
        // ebreak wins over a misaligned target and still moves the PC.
        COMMIT: begin
          o_commit_cnt <= o_commit_cnt + 1'b1;
          if (lat.ebreak) begin
            o_pc   <= npc;
            o_halt <= 1'b1;
            state  <= HALT;
          end else if (npc_misalign) begin
            o_misalign <= 1'b1;
            o_halt     <= 1'b1;
            state      <= HALT;
          end else begin
            o_pc         <= npc;
            o_post_valid <= 1'b1;
            state        <= NOTIFY;
          end
        end
        NOTIFY: begin
          if (i_post_ready) begin
            o_post_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbu_commit.sv
// Randomized bench for wbu_commit against an architectural model of PC, counter and halt state.
module tb_wbu_commit;

  localparam logic [31:0] RST_PC = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_pre_valid = 1'b0;
  logic        o_pre_ready;
  logic [31:0] i_res = '0;
  logic [31:0] i_pc_next = '0;
  logic [4:0]  i_rd = '0;
  logic        i_wen = 1'b0;
  logic        i_brch = 1'b0;
  logic        i_jump = 1'b0;
  logic        i_ebreak = 1'b0;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic [31:0] o_pc;
  logic        o_post_valid;
  logic        i_post_ready = 1'b0;
  logic        o_halt;
  logic        o_misalign;
  logic [63:0] o_commit_cnt;

  wbu_commit #(.RESET_PC(RST_PC), .CNT_W(64)) dut (
    .clock        (clock),
    .i_rst        (i_rst),
    .i_pre_valid  (i_pre_valid),
    .o_pre_ready  (o_pre_ready),
    .i_res        (i_res),
    .i_pc_next    (i_pc_next),
    .i_rd         (i_rd),
    .i_wen        (i_wen),
    .i_brch       (i_brch),
    .i_jump       (i_jump),
    .i_ebreak     (i_ebreak),
    .o_rf_wen     (o_rf_wen),
    .o_rf_waddr   (o_rf_waddr),
    .o_rf_wdata   (o_rf_wdata),
    .o_pc         (o_pc),
    .o_post_valid (o_post_valid),
    .i_post_ready (i_post_ready),
    .o_halt       (o_halt),
    .o_misalign   (o_misalign),
    .o_commit_cnt (o_commit_cnt)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [31:0] exp_pc;
  logic [63:0] exp_cnt;
  logic        exp_halt, exp_mis, exp_pre, exp_post, exp_wen;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model expectations change just after a rising edge; outputs are compared on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      checkOutput("pre_ready", o_pre_ready, exp_pre);
      checkOutput("post_valid", o_post_valid, exp_post);
      checkOutput("rf_wen", o_rf_wen, exp_wen);
      checkOutput("pc", o_pc, exp_pc);
      checkOutput("commit_cnt", o_commit_cnt, exp_cnt);
      checkOutput("halt", o_halt, exp_halt);
      checkOutput("misalign", o_misalign, exp_mis);
      if (exp_wen) begin
        checkOutput("rf_waddr", o_rf_waddr, exp_waddr);
        checkOutput("rf_wdata", o_rf_wdata, exp_wdata);
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic scramblePayload;
    i_res     = $urandom;
    i_pc_next = $urandom;
    i_rd      = 5'($urandom);
    i_wen     = 1'($urandom);
    i_brch    = 1'($urandom);
    i_jump    = 1'($urandom);
    i_ebreak  = 1'($urandom);
  endtask

  task automatic doReset(input int boot_delay);
    i_rst        = 1'b1;
    i_pre_valid  = 1'($urandom);
    i_post_ready = 1'($urandom);
    step;
    exp_pc   = RST_PC;
    exp_cnt  = '0;
    exp_halt = 1'b0;
    exp_mis  = 1'b0;
    exp_pre  = 1'b0;
    exp_post = 1'b0;
    exp_wen  = 1'b0;
    chk_en   = 1'b1;
    step;
    i_rst        = 1'b0;
    i_post_ready = (boot_delay == 0);
    step;
    exp_post = 1'b1;
    i_post_ready = 1'b0;
    repeat (boot_delay) step;
    i_post_ready = 1'b1;
    step;
    exp_post = 1'b0;
    exp_pre  = 1'b1;
    i_pre_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] res, input logic [31:0] pc_next,
                               input logic [4:0] rd, input logic wen, input logic brch,
                               input logic jump, input logic ebreak, input int gap,
                               input int delay, input bit abort);
    logic        taken;
    logic [31:0] npc;
    i_pre_valid = 1'b0;
    scramblePayload();
    repeat (gap) step;
    i_res = res; i_pc_next = pc_next; i_rd = rd; i_wen = wen;
    i_brch = brch; i_jump = jump; i_ebreak = ebreak;
    i_pre_valid  = 1'b1;
    i_post_ready = 1'($urandom);
    step;
    taken     = jump || (brch && res[0]);
    npc       = taken ? pc_next : exp_pc + 32'd4;
    exp_pre   = 1'b0;
    exp_wen   = wen && !brch && (rd != 5'd0);
    exp_waddr = rd;
    exp_wdata = res;
    i_pre_valid  = 1'($urandom);
    scramblePayload();
    i_post_ready = (delay == 0);
    step;
    exp_wen = 1'b0;
    exp_cnt = exp_cnt + 64'd1;
    if (ebreak) begin
      exp_pc   = npc;
      exp_halt = 1'b1;
    end else if (npc[1:0] != 2'b00) begin
      exp_halt = 1'b1;
      exp_mis  = 1'b1;
    end else begin
      exp_pc   = npc;
      exp_post = 1'b1;
    end
    if (exp_halt) begin
      i_pre_valid  = 1'b1;
      i_post_ready = 1'b1;
      repeat (3) step;
      return;
    end
    if (abort) begin
      doReset(int'($urandom_range(0, 2)));
      return;
    end
    repeat (delay) step;
    i_post_ready = 1'b1;
    step;
    exp_post = 1'b0;
    exp_pre  = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] tgt;
    logic        br, jp;
    doReset(0);
    checkOutput("boot_pc", o_pc, 32'h3000_0000);
    checkOutput("boot_cnt", o_commit_cnt, 64'd0);
    checkOutput("boot_pre_ready", o_pre_ready, 1'b1);

    applyStimulus(32'hDEAD_BEEF, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("alu_pc", o_pc, 32'h3000_0004);
    checkOutput("alu_cnt", o_commit_cnt, 64'd1);
    applyStimulus(32'h1, 32'h3000_0100, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0);
    checkOutput("br_taken_pc", o_pc, 32'h3000_0100);
    applyStimulus(32'h0, 32'h3000_0200, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("br_not_taken_pc", o_pc, 32'h3000_0104);
    applyStimulus(32'h1234_5678, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("x0_pc", o_pc, 32'h3000_0108);
    checkOutput("x0_cnt", o_commit_cnt, 64'd4);
    applyStimulus(32'hCAFE_0001, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 0, 5, 1'b0);
    checkOutput("slow_fetch_pc", o_pc, 32'h3000_010C);
    applyStimulus(32'h0, 32'hFFFF_FFFC, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(32'h5, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("wrap_pc", o_pc, 32'h0000_0000);
    checkOutput("wrap_cnt", o_commit_cnt, 64'd7);

    doReset(0);
    applyStimulus(32'h0, 32'h3000_0102, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    checkOutput("mis_flag", o_misalign, 1'b1);
    checkOutput("mis_halt", o_halt, 1'b1);
    checkOutput("mis_pc", o_pc, 32'h3000_0000);
    checkOutput("mis_pre_ready", o_pre_ready, 1'b0);
    doReset(1);
    checkOutput("rst_mis", o_misalign, 1'b0);
    checkOutput("rst_halt", o_halt, 1'b0);
    applyStimulus(32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    checkOutput("ebreak_halt", o_halt, 1'b1);
    checkOutput("ebreak_pc", o_pc, 32'h3000_0004);
    checkOutput("ebreak_post_valid", o_post_valid, 1'b0);

    for (int n = 0; n < 250; n++) begin
      if (exp_halt) doReset(int'($urandom_range(0, 2)));
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      br = ($urandom_range(0, 2) == 0);
      jp = !br && ($urandom_range(0, 3) == 0);
      applyStimulus($urandom, tgt, 5'($urandom), 1'($urandom), br, jp,
                    ($urandom_range(0, 29) == 0), int'($urandom_range(0, 2)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                    ($urandom_range(0, 39) == 0));
    end

    step;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
